// File: rtl/systolic_drain.sv
// Systolic array output collector: removes column skew, buffers aligned rows in a FIFO, drains via valid/ready.
// Optional build macro SYSTOLIC_DRAIN_RELU_EN clamps negative lanes to zero at FIFO write.
module systolic_drain #(
    parameter int COLS  = 4,
    parameter int SUM_W = 24,
    parameter int DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_valid,
    input  logic [COLS*SUM_W-1:0]     i_sums,
    output logic [COLS*SUM_W-1:0]     o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_overflow,
    output logic [$clog2(DEPTH):0]    o_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ROW_W = COLS * SUM_W;
    localparam logic [AW:0] LVL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] LVL_ZERO = {(AW+1){1'b0}};

    // Write-data shaping; identity unless the ReLU build option is enabled.
    function automatic logic [ROW_W-1:0] lane_clamp(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] res;
        res = row;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        for (int c = 0; c < COLS; c++) begin
            if (row[c*SUM_W + SUM_W - 1]) begin
                res[c*SUM_W +: SUM_W] = {SUM_W{1'b0}};
            end else begin
                res[c*SUM_W +: SUM_W] = row[c*SUM_W +: SUM_W];
            end
        end
`endif
        return res;
    endfunction

    logic [ROW_W-1:0] aligned_s;
    logic [COLS-2:0]  vld_r;
    logic [ROW_W-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      level_r;
    logic             ovf_r;
    logic             wreq_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;

    // Column c is delayed COLS-1-c cycles so all lanes of a row meet together.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign aligned_s[c*SUM_W +: SUM_W] = i_sums[c*SUM_W +: SUM_W];
        end else begin : g_dly
            logic [SUM_W-1:0] chain_r [D];
            // Unconditional per-column delay line.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < D; i++) chain_r[i] <= {SUM_W{1'b0}};
                end else begin
                    chain_r[0] <= i_sums[c*SUM_W +: SUM_W];
                    for (int i = 1; i < D; i++) chain_r[i] <= chain_r[i-1];
                end
            end
            assign aligned_s[c*SUM_W +: SUM_W] = chain_r[D-1];
        end
    end

    // Row-valid delay matching the column-0 data path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_r <= {(COLS-1){1'b0}};
        end else begin
            vld_r[0] <= i_valid;
            for (int i = 1; i < COLS-1; i++) vld_r[i] <= vld_r[i-1];
        end
    end

    // Handshake and FIFO admission decisions.
    always_comb begin
        wreq_s = vld_r[COLS-2];
        full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s  = o_valid && i_ready;
        push_s = wreq_s && (!full_s || pop_s);
        drop_s = wreq_s && full_s && !pop_s;
    end

    // Row storage; cleared on reset so o_data reads zero afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {ROW_W{1'b0}};
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= lane_clamp(aligned_s);
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= LVL_ZERO;
            rd_ptr_r <= LVL_ZERO;
            level_r  <= LVL_ZERO;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + LVL_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + LVL_ONE;
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
            if (drop_s) ovf_r <= 1'b1;
        end
    end

    assign o_valid    = (level_r != LVL_ZERO);
    assign o_level    = level_r;
    assign o_overflow = ovf_r;
    assign o_data     = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: directed scenarios plus random traffic against a queue-based row model.
module tb_systolic_drain;
    localparam int COLS  = 4;
    localparam int W     = 24;
    localparam int DEPTH = 4;
    localparam int ROW_W = COLS * W;
    localparam int MAXC  = 1024;

    logic             clock;
    logic             reset;
    logic             i_valid;
    logic [ROW_W-1:0] i_sums;
    logic [ROW_W-1:0] o_data;
    logic             o_valid;
    logic             i_ready;
    logic             o_overflow;
    logic [2:0]       o_level;

    systolic_drain #(.COLS(COLS), .SUM_W(W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_sums(i_sums),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_overflow(o_overflow), .o_level(o_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Input schedule by absolute cycle, and the row expected to align at each cycle.
    bit               sched_valid [MAXC];
    logic [W-1:0]     sched_lane  [MAXC][COLS];
    bit               align_valid [MAXC];
    logic [ROW_W-1:0] align_data  [MAXC];

    // Behavioural model: the FIFO is simply a queue of rows.
    logic [ROW_W-1:0] q [$];
    bit               ovf_m = 1'b0;

    function automatic logic [ROW_W-1:0] expect_store(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] r;
        r = row;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        for (int c = 0; c < COLS; c++)
            if ($signed(row[c*W +: W]) < 0) r[c*W +: W] = '0;
`endif
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] mk_row(input int r);
        logic [ROW_W-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*W +: W] = W'(10*r + c);
        return v;
    endfunction

    task automatic sched_row(input int t, input logic [ROW_W-1:0] row);
        sched_valid[t] = 1'b1;
        for (int c = 0; c < COLS; c++) sched_lane[t+c][c] = row[c*W +: W];
        align_valid[t+COLS-1] = 1'b1;
        align_data[t+COLS-1]  = row;
    endtask

    task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: compare against the model, drive inputs, advance the model at the edge.
    task automatic tick(input logic rdy);
        logic [ROW_W-1:0] tmp;
        chk("valid", ROW_W'(o_valid), ROW_W'(q.size() != 0));
        chk("level", ROW_W'(o_level), ROW_W'(q.size()));
        chk("overflow", ROW_W'(o_overflow), ROW_W'(ovf_m));
        if (q.size() != 0) chk("data", o_data, q[0]);
        i_valid = sched_valid[cyc];
        for (int c = 0; c < COLS; c++) i_sums[c*W +: W] = sched_lane[cyc][c];
        i_ready = rdy;
        @(posedge clock);
        if (!reset) begin
            if (q.size() != 0 && rdy) tmp = q.pop_front();
            if (align_valid[cyc]) begin
                if (q.size() < DEPTH) q.push_back(expect_store(align_data[cyc]));
                else ovf_m = 1'b1;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        int t0;
        logic [ROW_W-1:0] r1;
        logic [ROW_W-1:0] r1_exp;
        for (int k = 0; k < MAXC; k++)
            for (int c = 0; c < COLS; c++) sched_lane[k][c] = W'($urandom);
        reset = 1'b1; i_valid = 1'b0; i_sums = '0; i_ready = 1'b0;

        // Reset values after a 100 ns hold.
        #100;
        chk("rst_valid", ROW_W'(o_valid), ROW_W'(0));
        chk("rst_level", ROW_W'(o_level), ROW_W'(0));
        chk("rst_ovf", ROW_W'(o_overflow), ROW_W'(0));
        chk("rst_data", o_data, ROW_W'(0));
        #2;
        @(negedge clock);
        reset = 1'b0;

        // Single skewed row {43,-21,7,1}.
        t0 = cyc + 1;
        r1 = {24'd1, 24'd7, 24'hFFFFEB, 24'd43};
`ifdef SYSTOLIC_DRAIN_RELU_EN
        r1_exp = {24'd1, 24'd7, 24'd0, 24'd43};
`else
        r1_exp = r1;
`endif
        sched_row(t0, r1);
        while (cyc < t0 + 3) tick(1'b1);
        chk("s1_early", ROW_W'(o_valid), ROW_W'(0));
        tick(1'b1);
        chk("s1_valid", ROW_W'(o_valid), ROW_W'(1));
        chk("s1_data", o_data, r1_exp);
        repeat (3) tick(1'b1);

        // Six back-to-back rows with a ready consumer.
        t0 = cyc + 1;
        for (int r = 0; r < 6; r++) sched_row(t0 + r, mk_row(r));
        while (cyc < t0 + 4) tick(1'b1);
        for (int r = 0; r < 6; r++) begin
            chk("b2b_valid", ROW_W'(o_valid), ROW_W'(1));
            chk("b2b_data", o_data, mk_row(r));
            tick(1'b1);
        end
        chk("b2b_empty", ROW_W'(o_valid), ROW_W'(0));
        chk("b2b_ovf", ROW_W'(o_overflow), ROW_W'(0));

        // Fill and drop: five rows into a four-deep FIFO with no consumer.
        t0 = cyc + 1;
        for (int r = 0; r < 5; r++) sched_row(t0 + r, mk_row(10 + r));
        while (cyc < t0 + 8) tick(1'b0);
        chk("fill_level", ROW_W'(o_level), ROW_W'(4));
        chk("fill_ovf", ROW_W'(o_overflow), ROW_W'(1));
        for (int r = 0; r < 4; r++) begin
            chk("fill_data", o_data, mk_row(10 + r));
            tick(1'b1);
        end
        chk("fill_empty", ROW_W'(o_valid), ROW_W'(0));
        repeat (2) tick(1'b1);

        // Reset mid-row with two rows stored and a third in flight.
        t0 = cyc + 1;
        sched_row(t0, mk_row(20));
        sched_row(t0 + 1, mk_row(21));
        sched_row(t0 + 6, mk_row(22));
        while (cyc < t0 + 5) tick(1'b0);
        chk("mid_level2", ROW_W'(o_level), ROW_W'(2));
        while (cyc < t0 + 8) tick(1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_level", ROW_W'(o_level), ROW_W'(0));
        chk("mid_rst_valid", ROW_W'(o_valid), ROW_W'(0));
        chk("mid_rst_ovf", ROW_W'(o_overflow), ROW_W'(0));
        q.delete();
        ovf_m = 1'b0;
        for (int k = cyc; k < MAXC; k++) align_valid[k] = 1'b0;
        repeat (2) tick(1'b0);
        reset = 1'b0;
        repeat (8) tick(1'b1);
        chk("mid_none", ROW_W'(o_valid), ROW_W'(0));

        // Full FIFO with a push and pop on the same edge.
        t0 = cyc + 1;
        for (int r = 0; r < 4; r++) sched_row(t0 + r, mk_row(30 + r));
        sched_row(t0 + 5, mk_row(34));
        while (cyc < t0 + 8) tick(1'b0);
        chk("full_level", ROW_W'(o_level), ROW_W'(4));
        tick(1'b1);
        chk("pp_level", ROW_W'(o_level), ROW_W'(4));
        chk("pp_ovf", ROW_W'(o_overflow), ROW_W'(0));
        for (int r = 1; r < 5; r++) begin
            chk("pp_data", o_data, mk_row(30 + r));
            tick(1'b1);
        end
        chk("pp_empty", ROW_W'(o_valid), ROW_W'(0));

        // Backpressure: ready 0,0,1 holds the head row, then pops exactly once.
        t0 = cyc + 1;
        sched_row(t0, mk_row(40));
        sched_row(t0 + 1, mk_row(41));
        while (cyc < t0 + 5) tick(1'b0);
        chk("bp_data0", o_data, mk_row(40));
        tick(1'b0);
        chk("bp_data1", o_data, mk_row(40));
        tick(1'b0);
        chk("bp_data2", o_data, mk_row(40));
        tick(1'b1);
        chk("bp_level", ROW_W'(o_level), ROW_W'(1));
        chk("bp_next", o_data, mk_row(41));
        repeat (3) tick(1'b1);

        // Random rows, lanes and consumer readiness.
        t0 = cyc + 1;
        for (int t = t0; t < t0 + 200; t++) begin
            if ($urandom_range(0, 2) != 0) begin
                logic [ROW_W-1:0] rr;
                for (int c = 0; c < COLS; c++) rr[c*W +: W] = W'($urandom);
                sched_row(t, rr);
            end
        end
        while (cyc < t0 + 210) tick(1'($urandom_range(0, 1)));
        repeat (8) tick(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
